// File: rtl/mig_ui_adapter.sv
// Single-outstanding bridge from a 128-bit cache-line request port to the MIG DDR3 app_* user interface.
// One line per request: write = command + one write-data beat, read = command + one captured read beat.
module mig_ui_adapter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk_core,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_write,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                err,
  input  logic                init_calib_complete,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  input  logic                app_rd_data_end
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;

  typedef enum logic [2:0] {INIT, IDLE, WR, RD_CMD, RD_WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                req_ready_nxt, resp_valid_nxt, resp_write_nxt, err_nxt;
  logic [DATA_W-1:0]   resp_rdata_nxt;
  logic [ADDR_W-1:0]   app_addr_nxt;
  logic [2:0]          app_cmd_nxt;
  logic                app_en_nxt, app_wdf_wren_nxt, app_wdf_end_nxt;
  logic [DATA_W-1:0]   app_wdf_data_nxt;
  logic [MASK_W-1:0]   app_wdf_mask_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                cmd_done, cmd_done_nxt, wdf_done, wdf_done_nxt;

  // Line-aligned address: the low nibble is always a full-line offset.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[3:0];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt        = state;
    req_ready_nxt    = 1'b0;
    resp_valid_nxt   = resp_valid;
    resp_write_nxt   = resp_write;
    resp_rdata_nxt   = resp_rdata;
    err_nxt          = err;
    app_addr_nxt     = app_addr;
    app_cmd_nxt      = app_cmd;
    app_en_nxt       = app_en;
    app_wdf_data_nxt = app_wdf_data;
    app_wdf_mask_nxt = app_wdf_mask;
    app_wdf_wren_nxt = app_wdf_wren;
    app_wdf_end_nxt  = app_wdf_end;
    cnt_nxt          = cnt;
    cmd_done_nxt     = cmd_done;
    wdf_done_nxt     = wdf_done;

    case (state)
      INIT: begin
        if (init_calib_complete) state_nxt = IDLE;
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          app_addr_nxt = {1'b0, req_addr[ADDR_W-1:4], 3'b000};
          app_en_nxt   = 1'b1;
          cmd_done_nxt = 1'b0;
          wdf_done_nxt = 1'b0;
          if (req_write) begin
            state_nxt        = WR;
            app_cmd_nxt      = CMD_WR;
            app_wdf_data_nxt = req_wdata;
            app_wdf_mask_nxt = ~req_wmask;
            app_wdf_wren_nxt = 1'b1;
            app_wdf_end_nxt  = 1'b1;
          end else begin
            state_nxt   = RD_CMD;
            app_cmd_nxt = CMD_RD;
          end
        end else if (!init_calib_complete) begin
          state_nxt = INIT;
        end
      end
      WR: begin
        // Command and data handshakes finish independently; done flags remember each.
        if (app_en && app_rdy) begin
          app_en_nxt   = 1'b0;
          cmd_done_nxt = 1'b1;
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          app_wdf_wren_nxt = 1'b0;
          app_wdf_end_nxt  = 1'b0;
          wdf_done_nxt     = 1'b1;
        end
        if (cmd_done && wdf_done) begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_write_nxt = 1'b1;
        end
      end
      RD_CMD: begin
        if (app_en && app_rdy) begin
          app_en_nxt = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (app_rd_data_valid && app_rd_data_end) begin
          resp_rdata_nxt = app_rd_data;
          resp_write_nxt = 1'b0;
          resp_valid_nxt = 1'b1;
          state_nxt      = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_nxt        = 1'b1;
          resp_rdata_nxt = '0;
          resp_write_nxt = 1'b0;
          resp_valid_nxt = 1'b1;
          state_nxt      = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          resp_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase

    // Ready only while settled in IDLE with calibration held.
    req_ready_nxt = (state == IDLE) && (state_nxt == IDLE) && init_calib_complete;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state        <= INIT;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_write   <= 1'b0;
      resp_rdata   <= '0;
      err          <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= 3'b000;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      cnt          <= '0;
      cmd_done     <= 1'b0;
      wdf_done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      req_ready    <= req_ready_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_write   <= resp_write_nxt;
      resp_rdata   <= resp_rdata_nxt;
      err          <= err_nxt;
      app_addr     <= app_addr_nxt;
      app_cmd      <= app_cmd_nxt;
      app_en       <= app_en_nxt;
      app_wdf_data <= app_wdf_data_nxt;
      app_wdf_mask <= app_wdf_mask_nxt;
      app_wdf_wren <= app_wdf_wren_nxt;
      app_wdf_end  <= app_wdf_end_nxt;
      cnt          <= cnt_nxt;
      cmd_done     <= cmd_done_nxt;
      wdf_done     <= wdf_done_nxt;
    end
  end

endmodule
